muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready handshake on input and output.
//  Replaces single-cycle combinational MUL/DIV paths in the execute stage; the integer ALU keeps the base ops.
//  Executes one operation at a time, tagged with the destination register, and holds the result until the consumer accepts it.
// PARAMETERS
//  XLEN   32  operand/result width; must be even and >= 4
//  TAG_W  5   width of the pass-through tag (rd index)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst_n      in   1      reset: synchronous, active-low
//  flush      in   1      abort current operation (pipeline kill)
//  in_valid   in   1      request valid
//  in_ready   out  1      unit can accept; high only in IDLE
//  op         in   3      funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  rs1        in   XLEN   operand A (dividend / multiplicand)
//  rs2        in   XLEN   operand B (divisor / multiplier)
//  tag        in   TAG_W  tag captured with the request
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts the result
//  result     out  XLEN   result
//  out_tag    out  TAG_W  tag of the result
//  neg_flag   out  1      result[XLEN-1]
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, result=0, out_tag=0, internal counters/regs 0; in_ready=1 after reset.
//  FSM states: IDLE -> (accept) CALC or DONE; CALC -> DONE when counter reaches XLEN; DONE -> IDLE on out_valid&&out_ready.
//  Accept = in_valid && in_ready. op, rs1, rs2 and tag are latched at accept; input changes afterwards are ignored.
//  Sign handling: operand signedness comes from op (MULH: both signed; MULHSU: A signed, B unsigned; MULHU/DIVU/REMU: unsigned).
//   Magnitudes are used internally. Product is negated if the operand signs differ. Quotient is negated if the signs differ.
//   Remainder takes the sign of the dividend.
//  Divide: restoring division, 1 bit per cycle, XLEN cycles in CALC. Accept at cycle t gives out_valid at t+XLEN+1.
//  Divide special cases go IDLE->DONE directly, with out_valid at t+1:
//   rs2==0: quotient = all ones, remainder = rs1.
//   signed overflow (rs1 = 1<<(XLEN-1), rs2 = all ones, DIV/REM): quotient = rs1, remainder = 0.
//  Multiply: 2*XLEN-bit product. MUL returns the low half. MULH/MULHSU/MULHU return the high half.
//  DONE: out_valid=1. result and out_tag stay stable until the handshake. The return to IDLE takes effect on the next cycle.
//   No same-cycle re-accept.
//  flush: goes to IDLE on the next edge from any state, out_valid=0, result discarded. Priority: rst_n > flush > handshake.
//   flush in the accept cycle cancels that request.
//  Counter counts 0..XLEN-1. It must not wrap into a second pass, and it clears on every accept.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined: multiply uses one registered array product, IDLE->DONE, out_valid at t+1.
//  MULDIV_FAST_MUL_EN undefined: multiply uses iterative shift-add, 1 bit/cycle, XLEN cycles in CALC, out_valid at t+XLEN+1,
//   sharing the divider's shift register and counter.
//  Divide latency is the same in both builds. Results are bit-identical in both builds.
// STRUCTURE
//  Package muldiv_pkg: op encodings (localparam/enum for the 8 funct3 values), FSM state enum (IDLE, CALC, DONE),
//   helper functions is_div/is_rem/a_signed/b_signed.
//  Sub-module muldiv_iter_core: shared XLEN-step shift/add-subtract datapath with iteration counter and done strobe.
//  muldiv_unit owns the handshake, sign pre/post-processing, special-case bypass and output registers.
// TESTING (XLEN=32, both macro settings)
//  MULHU/MULH/MUL, rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE / 0x00000000 / 0x00000001, out_tag = input tag.
//  MULHSU, rs1=0xFFFFFFFF (-1), rs2=0x00000002 -> 0xFFFFFFFF.
//  Latency: 33 cycles without the macro, 1 cycle with it.
//  DIV/REM, rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD / 0xFFFFFFFF. out_valid exactly 33 cycles after accept.
//  DIVU/REMU, rs1=5, rs2=0 -> 0xFFFFFFFF / 0x00000005.
//  DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000 / 0x00000000. Both cases out_valid at t+1.
//  Backpressure: hold out_ready=0 for 10 cycles in DONE -> result, out_tag and out_valid stable, in_ready=0, in_valid ignored.
//   Then out_ready=1 -> in_ready=1 next cycle.
//  flush at CALC cycle 10 of a DIV -> out_valid never rises, in_ready=1 next cycle, next MUL gives the correct result.
//   rst_n=0 mid-CALC -> all outputs 0 after the edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M/RV64M multiply/divide unit: funct3 encodings, FSM states
// and operand-signedness helpers.
package muldiv_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_div(input op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic a_signed(input op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_signed(input op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared one-bit-per-cycle datapath: shift-add multiply or restoring divide on unsigned magnitudes.
// hi_c/lo_c present the post-step values so the final step can be captured on the done_c edge.
module muldiv_iter_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            load,
    input  logic            run,
    input  logic            div_mode,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done_c,
    output logic [XLEN-1:0] hi_c,
    output logic [XLEN-1:0] lo_c
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  b_q;
    logic             div_q;
    logic             running_q;
    logic [CNT_W-1:0] cnt_q;

    logic [XLEN:0]    shifted;
    logic [XLEN:0]    sum;
    logic             ge;

    // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
    // Multiply: lo holds the multiplier, {hi,lo} shifts right one bit per step.
    always_comb begin
        shifted = {hi_q, lo_q[XLEN-1]};
        ge      = shifted >= {1'b0, b_q};
        sum     = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
        hi_c    = hi_q;
        lo_c    = lo_q;
        if (div_q) begin
            hi_c = ge ? XLEN'(shifted - {1'b0, b_q}) : shifted[XLEN-1:0];
            lo_c = {lo_q[XLEN-2:0], ge};
        end else begin
            hi_c = sum[XLEN:1];
            lo_c = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    assign done_c = running_q && (cnt_q == CNT_W'(XLEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            div_q     <= 1'b0;
            running_q <= 1'b0;
            cnt_q     <= '0;
        end else if (flush) begin
            running_q <= 1'b0;
        end else if (load) begin
            hi_q      <= '0;
            lo_q      <= a;
            b_q       <= b;
            div_q     <= div_mode;
            running_q <= run;
            cnt_q     <= '0;
        end else if (running_q) begin
            hi_q <= hi_c;
            lo_q <= lo_c;
            if (done_c) begin
                running_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready handshake.
// Define MULDIV_FAST_MUL_EN for a single-cycle registered array multiply; divide is always iterative.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             neg_flag,
    output logic             busy
);

    state_e           state;
    op_e              op_q;
    logic             neg_q;

    op_e              op_c;
    logic             a_neg, b_neg, sign_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             div_zero, div_ovf, bypass, accept, core_run;
    logic [XLEN-1:0]  bypass_res, iter_res;
    logic [2*XLEN-1:0] fast_prod;

    logic             core_done_c;
    logic [XLEN-1:0]  core_hi_c, core_lo_c;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
    assign fast_prod = (2*XLEN)'(a_mag) * (2*XLEN)'(b_mag);
`else
    localparam bit FAST_MUL = 1'b0;
    assign fast_prod = '0;
`endif

    // Apply the result sign to an unsigned quotient/remainder or double-width product.
    function automatic logic [XLEN-1:0] finish_res(input op_e f_op, input logic neg,
                                                   input logic [XLEN-1:0] hi,
                                                   input logic [XLEN-1:0] lo);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   v;
        if (is_div(f_op)) begin
            v = is_rem(f_op) ? hi : lo;
            v = neg ? XLEN'(-v) : v;
        end else begin
            p = {hi, lo};
            p = neg ? (2*XLEN)'(-p) : p;
            v = (f_op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        end
        return v;
    endfunction

    assign op_c   = op_e'(op);
    assign accept = in_valid && in_ready;

    always_comb begin
        a_neg    = a_signed(op_c) && rs1[XLEN-1];
        b_neg    = b_signed(op_c) && rs2[XLEN-1];
        a_mag    = a_neg ? XLEN'(-rs1) : rs1;
        b_mag    = b_neg ? XLEN'(-rs2) : rs2;
        sign_neg = is_rem(op_c) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div(op_c) && (rs2 == '0);
        div_ovf  = (op_c inside {OP_DIV, OP_REM}) && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (rs2 == '1);
        bypass   = div_zero || div_ovf || (FAST_MUL && !is_div(op_c));
        core_run = !bypass;
        if (div_zero) begin
            bypass_res = is_rem(op_c) ? rs1 : '1;
        end else if (div_ovf) begin
            bypass_res = is_rem(op_c) ? '0 : rs1;
        end else begin
            bypass_res = finish_res(op_c, sign_neg, fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0]);
        end
        iter_res = finish_res(op_q, neg_q, core_hi_c, core_lo_c);
    end

    muldiv_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .load     (accept),
        .run      (core_run),
        .div_mode (is_div(op_c)),
        .a        (a_mag),
        .b        (b_mag),
        .done_c   (core_done_c),
        .hi_c     (core_hi_c),
        .lo_c     (core_lo_c)
    );

    // Handshake FSM; flush outranks everything except reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
            neg_flag  <= 1'b0;
            op_q      <= OP_MUL;
            neg_q     <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= op_c;
                        neg_q    <= sign_neg;
                        out_tag  <= tag;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (bypass) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= bypass_res;
                            neg_flag  <= bypass_res[XLEN-1];
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (core_done_c) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= iter_res;
                        neg_flag  <= iter_res[XLEN-1];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32); honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, neg_flag, busy;
    logic [2:0]  op;
    logic [31:0] rs1, rs2, result;
    logic [4:0]  tag, out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .tag       (tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .neg_flag  (neg_flag),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Present one request; returns after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        op = o; rs1 = a; rs2 = b; tag = t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'd0; rs1 = '0; rs2 = '0; tag = '0;
    endtask

    // Edges from the accept edge (counted as 1) until out_valid is observed.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        issue(o, a, b, t);
        wait_valid(lat);
        check({name, "_res"}, 64'(result), 64'(exp_res));
        check({name, "_tag"}, 64'(out_tag), 64'(t));
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_neg"}, 64'(neg_flag), 64'(exp_res[31]));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        stable;
        logic        seen;
        logic [31:0] held_res;
        int          lat;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; rs1 = '0; rs2 = '0; tag = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    64'(result),    64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_busy",      64'(busy),      64'd0);

        run_op("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, MUL_LAT);
        run_op("mulh",   MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0000, MUL_LAT);
        run_op("mul",    MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0001, MUL_LAT);
        run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, MUL_LAT);
        run_op("div",    DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD, 33);
        run_op("rem",    REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 33);
        run_op("divu",   DIVU,   32'hFFFF_FFFF, 32'h0000_0010, 5'd9,  32'h0FFF_FFFF, 33);
        run_op("remu",   REMU,   32'hFFFF_FFFF, 32'h0000_0010, 5'd10, 32'h0000_000F, 33);
        run_op("divu0",  DIVU,   32'h0000_0005, 32'h0000_0000, 5'd11, 32'hFFFF_FFFF, 1);
        run_op("remu0",  REMU,   32'h0000_0005, 32'h0000_0000, 5'd12, 32'h0000_0005, 1);
        run_op("divovf", DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
        run_op("removf", REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1);

        // Backpressure: hold the result while a new request is offered.
        issue(MUL, 32'd7, 32'd6, 5'd21);
        wait_valid(lat);
        check("bp_valid", 64'(out_valid), 64'd1);
        held_res = result;
        stable = 1'b1;
        op = DIVU; rs1 = 32'd99; rs2 = 32'd3; tag = 5'd30; in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!out_valid || result !== 32'd42 || out_tag !== 5'd21 || in_ready) stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_result", 64'(held_res), 64'd42);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_in_ready_after", 64'(in_ready), 64'd1);
        check("bp_valid_after", 64'(out_valid), 64'd0);

        // Flush mid-divide.
        issue(DIV, 32'd100, 32'd7, 5'd17);
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_valid", 64'(seen), 64'd0);
        run_op("mul_after_flush", MUL, 32'd123, 32'd456, 5'd18, 32'h0000_DB18, MUL_LAT);

        // Reset in the middle of a divide.
        issue(DIV, 32'd1000, 32'd3, 5'd19);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_valid",  64'(out_valid), 64'd0);
        check("rst_mid_result", 64'(result),    64'd0);
        check("rst_mid_tag",    64'(out_tag),   64'd0);
        check("rst_mid_busy",   64'(busy),      64'd0);
        check("rst_mid_neg",    64'(neg_flag),  64'd0);
        check("rst_mid_ready",  64'(in_ready),  64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
